serial_subtractor: RTL and testbench

//  Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, processed DIGIT bits per clock, LSB first.

---
 rtl/serial_sub_pkg.sv | 26 ++
 rtl/sub_digit.sv | 39 +++
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_subtractor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared definitions for the serial subtractor: control state
//            encodings and a ceil(log2) helper for sizing the digit counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Ceiling of log2(n); returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_digit.sv
`default_nettype none
// ============================================================================
// Module   : sub_digit
// Purpose  : Combinational DIGIT-bit ripple-borrow subtractor: d = x - y - bi.
// Ports    : x  [DIGIT] in  - minuend digit
//            y  [DIGIT] in  - subtrahend digit
//            bi [1]     in  - borrow in
//            d  [DIGIT] out - difference digit
//            bo [1]     out - borrow out
// Revision : 1.0 - initial release
// ============================================================================
module sub_digit
    import serial_sub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic w_brw;

    // Borrow ripples from bit 0 upward; a borrow is produced when y exceeds
    // x at this bit, or when they are equal and a borrow is already pending.
    always_comb begin
        w_brw = bi;
        d     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]  = x[i] ^ y[i] ^ w_brw;
            w_brw = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_brw);
        end
        bo = w_brw;
    end

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Multi-cycle WIDTH-bit subtractor, diff = a - b - bin, processed
//            DIGIT bits per clock LSB first, with start/busy/done handshake.
// Ports    : clk    in  1      rising-edge clock
//            rst    in  1      asynchronous active-high reset
//            start  in  1      request, sampled only while idle
//            a      in  WIDTH  minuend, captured on accepted start
//            b      in  WIDTH  subtrahend, captured on accepted start
//            bin    in  1      borrow in, captured on accepted start
//            busy   out 1      high whenever not idle
//            done   out 1      one-cycle pulse, result valid from this cycle
//            diff   out WIDTH  result, held until the next done
//            borrow out 1      final borrow out, held until the next done
//            ovf    out 1      two's-complement overflow (only with
//                              SERIAL_SUB_OVF_EN defined)
// Config   : `define SERIAL_SUB_OVF_EN adds the ovf output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (clog2(K) < 1) ? 1 : clog2(K);
    localparam logic [CW-1:0] c_cnt_last = CW'(K - 1);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic             r_brw;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [DIGIT-1:0] w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_diff_next;

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .x  (r_a_sh[DIGIT-1:0]),
        .y  (r_b_sh[DIGIT-1:0]),
        .bi (r_brw),
        .d  (w_d),
        .bo (w_bo)
    );

    // New digit enters at the MSB end; after K steps the LSB digit has been
    // pushed down to bit 0 and the register holds the full difference.
    assign w_diff_next = WIDTH'({w_d, r_diff_sh} >> DIGIT);

    assign w_accept = (r_state == c_st_idle) && start;
    assign w_step   = (r_state == c_st_run);
    assign w_last   = w_step && (r_cnt == c_cnt_last);

    assign busy = (r_state != c_st_idle);
    assign done = (r_state == c_st_done);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start)  w_state_nxt = c_st_run;
            c_st_run:  if (w_last) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_brw     <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a_sh <= a;
                r_b_sh <= b;
                r_brw  <= bin;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_a_sh    <= r_a_sh >> DIGIT;
                r_b_sh    <= r_b_sh >> DIGIT;
                r_brw     <= w_bo;
                r_diff_sh <= w_diff_next;
                r_cnt     <= r_cnt + CW'(1);
            end
            if (w_last) begin
                diff   <= w_diff_next;
                borrow <= w_bo;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out during the run, so keep copies.
    logic r_a_msb;
    logic r_b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (w_last) begin
                ovf <= (r_a_msb != r_b_msb) && (w_diff_next[WIDTH-1] != r_a_msb);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor. Two instances
//            (WIDTH=8 with DIGIT=1 and DIGIT=4) are driven one at a time;
//            expected results and done timing go into a scoreboard queue
//            that a negedge monitor pops whenever an instance pulses done.
// Config   : honours SERIAL_SUB_OVF_EN (checks ovf when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         due;
    } exp_t;

    typedef struct {
        int         inst;
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       br;
        logic       ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_s  [2];
    logic [7:0] a_s      [2];
    logic [7:0] b_s      [2];
    logic       bin_s    [2];
    logic       busy_s   [2];
    logic       done_s   [2];
    logic [7:0] diff_s   [2];
    logic       borrow_s [2];
    logic       ovf_s    [2];

    int   checks = 0;
    int   errors = 0;
    int   pcnt   = 0;
    exp_t sbq[$];

    localparam int c_k[2] = '{8, 2};

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

`ifndef SERIAL_SUB_OVF_EN
    initial begin
        ovf_s[0] = 1'b0;
        ovf_s[1] = 1'b0;
    end
`endif

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s[0]),
        .a      (a_s[0]),
        .b      (b_s[0]),
        .bin    (bin_s[0]),
        .busy   (busy_s[0]),
        .done   (done_s[0]),
        .diff   (diff_s[0]),
        .borrow (borrow_s[0])
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf_s[0])
`endif
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s[1]),
        .a      (a_s[1]),
        .b      (b_s[1]),
        .bin    (bin_s[1]),
        .busy   (busy_s[1]),
        .done   (done_s[1]),
        .diff   (diff_s[1]),
        .borrow (borrow_s[1])
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf_s[1])
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation, both in
    // value and in the cycle it appears.
    always @(negedge clk) begin : p_monitor
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!rst && done_s[i] === 1'b1) begin
                if (sbq.size() == 0 || sbq[0].inst != i) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_done: inst %0d got done=1 expected no done", i);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("diff[%0d]", i),    32'(diff_s[i]),   32'(e.d));
                    chk($sformatf("borrow[%0d]", i),  32'(borrow_s[i]), 32'(e.br));
                    chk($sformatf("latency[%0d]", i), 32'(pcnt),        32'(e.due));
`ifdef SERIAL_SUB_OVF_EN
                    chk($sformatf("ovf[%0d]", i),     32'(ovf_s[i]),    32'(e.ov));
`endif
                end
            end
        end
    end

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy_s[inst] !== 1'b0) && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 40) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL timeout: inst %0d got no completion expected done within 40 cycles", inst);
            sbq.delete();
        end
    endtask

    task automatic run_op(input vec_t v, input bit spam);
        exp_t e;
        int   n;
        @(negedge clk);
        a_s[v.inst]     = v.a;
        b_s[v.inst]     = v.b;
        bin_s[v.inst]   = v.bin;
        start_s[v.inst] = 1'b1;
        e.inst = v.inst;
        e.d    = v.d;
        e.br   = v.br;
        e.ov   = v.ov;
        e.due  = pcnt + c_k[v.inst] + 1;
        sbq.push_back(e);
        @(negedge clk);
        chk($sformatf("busy_after_accept[%0d]", v.inst), 32'(busy_s[v.inst]), 32'd1);
        // Operands are not re-sampled after acceptance.
        a_s[v.inst]   = 8'($urandom);
        b_s[v.inst]   = 8'($urandom);
        bin_s[v.inst] = 1'($urandom);
        if (spam) begin
            n = 0;
            while (busy_s[v.inst] === 1'b1 && n < 40) begin
                start_s[v.inst] = 1'b1;
                a_s[v.inst]     = 8'($urandom);
                b_s[v.inst]     = 8'($urandom);
                @(negedge clk);
                n = n + 1;
            end
        end
        start_s[v.inst] = 1'b0;
        wait_idle(v.inst);
    endtask

    vec_t vecs[10] = '{
        '{0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0},
        '{0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0},
        '{0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0},
        '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
        '{0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
        '{0, 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0},
        '{1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1},
        '{1, 8'h12, 8'h34, 1'b1, 8'hDD, 1'b1, 1'b0},
        '{1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
        '{1, 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0}
    };

    vec_t spam0  = '{0, 8'h3C, 8'h0F, 1'b1, 8'h2C, 1'b0, 1'b0};
    vec_t spam1  = '{1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vec_t post_r = '{0, 8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1};

    initial begin
        watchdog_start();
    end

    task automatic watchdog_start();
        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation got stuck expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            a_s[i]     = '0;
            b_s[i]     = '0;
            bin_s[i]   = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_busy[%0d]", i),   32'(busy_s[i]),   32'd0);
            chk($sformatf("reset_done[%0d]", i),   32'(done_s[i]),   32'd0);
            chk($sformatf("reset_diff[%0d]", i),   32'(diff_s[i]),   32'd0);
            chk($sformatf("reset_borrow[%0d]", i), 32'(borrow_s[i]), 32'd0);
        end
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        // Back-to-back start requests while busy must be ignored.
        run_op(spam0, 1'b1);
        repeat (3) @(negedge clk);
        chk("diff_held[0]", 32'(diff_s[0]), 32'h2C);
        run_op(spam1, 1'b1);
        repeat (3) @(negedge clk);
        chk("diff_held[1]", 32'(diff_s[1]), 32'hF0);

        // Asynchronous reset in the middle of a run discards the operation.
        @(negedge clk);
        a_s[0]     = 8'h55;
        b_s[0]     = 8'h11;
        bin_s[0]   = 1'b0;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",   32'(busy_s[0]),   32'd0);
        chk("midrst_done",   32'(done_s[0]),   32'd0);
        chk("midrst_diff",   32'(diff_s[0]),   32'd0);
        chk("midrst_borrow", 32'(borrow_s[0]), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("midrst_ovf",    32'(ovf_s[0]),    32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_stays_idle", 32'(busy_s[0]), 32'd0);
        run_op(post_r, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
